// File: rtl/uart_instr_server.sv
// UART instruction server: receives a 4-byte little-endian PC, reads the word
// from program RAM (NOP for bad PCs) and returns it as 4 little-endian bytes.
module uart_instr_server #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned TIMEOUT_BITS = 20,
  parameter logic [31:0] NOP_WORD     = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              tx,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic              busy,
  output logic [31:0]       last_pc,
  output logic              resp_done,
  output logic              addr_err,
  output logic              frame_err
);
  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned GAP_W   = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // Set bits mark PCs that are misaligned or beyond the RAM depth
  localparam logic [31:0] BAD_MASK = ~(((32'd1 << ADDR_W) - 32'd1) << 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LOOKUP, S_SEND} st_t;

  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  rx_st_t           r_rx_st;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_tick, w_rx_done, w_rx_ferr;

  st_t              r_state, w_state_nx;
  logic [1:0]       r_idx;
  logic [31:0]      r_pc, w_pc_full, r_last_pc;
  logic [GAP_W-1:0] r_gap;
  logic             w_timeout, w_store, w_abort, w_last_byte, w_read, w_pc_bad;
  logic             r_bad, r_busy, r_resp_done, r_addr_err, r_frame_err;

  logic [31:0]      r_ram [DEPTH];
  logic [31:0]      r_rd;

  logic             r_tx, r_tx_active, r_tx_load, w_tx_tick, w_tx_last;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_bit;
  logic [1:0]       r_tx_byte;
  logic [31:0]      r_tx_sh;

  assign tx        = r_tx;
  assign busy      = r_busy;
  assign last_pc   = r_last_pc;
  assign resp_done = r_resp_done;
  assign addr_err  = r_addr_err;
  assign frame_err = r_frame_err;

  // Receiver: 2-FF sync, falling-edge start, mid-bit sampling
  assign w_rx_tick = (r_rx_cnt == BIT_LAST);
  assign w_rx_done = (r_rx_st == RX_STOP) && w_rx_tick && r_rx_s2;
  assign w_rx_ferr = (r_rx_st == RX_STOP) && w_rx_tick && !r_rx_s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_st    <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_st)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (r_rx_prev && !r_rx_s2) r_rx_st <= RX_START;
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_st  <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_rx_tick) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
            if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: begin
          if (w_rx_tick) begin
            r_rx_cnt <= '0;
            r_rx_st  <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign w_pc_full = {r_rx_shift, r_pc[23:0]};
  assign w_pc_bad  = |(w_pc_full & BAD_MASK);
  assign w_timeout = (r_state == S_COLLECT) && (r_gap == GAP_W'(TMO_CYC));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:    if (w_rx_done) w_state_nx = S_COLLECT;
      S_COLLECT: begin
        if (w_rx_ferr || w_timeout)            w_state_nx = S_IDLE;
        else if (w_rx_done && r_idx == 2'd3)   w_state_nx = S_LOOKUP;
      end
      S_LOOKUP:  w_state_nx = S_SEND;
      default:   if (w_tx_last) w_state_nx = S_IDLE;
    endcase
  end

  // Bytes received during LOOKUP/SEND are never stored
  always_comb begin
    w_store     = 1'b0;
    w_abort     = 1'b0;
    w_last_byte = 1'b0;
    w_read      = 1'b0;
    case (r_state)
      S_IDLE:    w_store = w_rx_done;
      S_COLLECT: begin
        w_abort     = w_rx_ferr || w_timeout;
        w_store     = w_rx_done;
        w_last_byte = w_rx_done && (r_idx == 2'd3);
      end
      S_LOOKUP:  w_read = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx       <= '0;
      r_pc        <= '0;
      r_gap       <= '0;
      r_bad       <= 1'b0;
      r_busy      <= 1'b0;
      r_last_pc   <= '0;
      r_resp_done <= 1'b0;
      r_addr_err  <= 1'b0;
      r_frame_err <= 1'b0;
      r_tx_load   <= 1'b0;
    end else begin
      r_resp_done <= w_tx_last;
      r_addr_err  <= w_last_byte && w_pc_bad;
      r_frame_err <= w_rx_ferr || w_timeout;
      r_busy      <= (w_state_nx != S_IDLE);
      r_tx_load   <= w_read;
      if (w_last_byte) r_bad <= w_pc_bad;
      if (w_tx_last)   r_last_pc <= r_pc;
      if (w_abort || w_last_byte) r_idx <= '0;
      else if (w_store)           r_idx <= r_idx + 1'b1;
      if (w_store) r_pc[{r_idx, 3'b000} +: 8] <= r_rx_shift;
      // Inter-byte gap only counts while the receiver line is idle
      if (r_state == S_COLLECT && r_rx_st == RX_IDLE && !w_timeout) r_gap <= r_gap + 1'b1;
      else                                                           r_gap <= '0;
    end
  end

  // Program RAM: write port ignores reset; read-first on collision
  always_ff @(posedge clk) begin
    if (prog_we) r_ram[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (w_read) r_rd <= r_ram[r_pc[ADDR_W+1:2]];
  end

  // Transmitter: 4 back-to-back 8N1 bytes, LSB first
  assign w_tx_tick = r_tx_active && (r_tx_cnt == BIT_LAST);
  assign w_tx_last = w_tx_tick && (r_tx_bit == 4'd9) && (r_tx_byte == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx        <= 1'b1;
      r_tx_active <= 1'b0;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_byte   <= '0;
      r_tx_sh     <= '0;
    end else if (r_tx_load) begin
      r_tx_sh     <= r_bad ? NOP_WORD : r_rd;
      r_tx        <= 1'b0;
      r_tx_active <= 1'b1;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_tx_byte   <= '0;
    end else if (r_tx_active) begin
      if (!w_tx_tick) begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end else begin
        r_tx_cnt <= '0;
        if (r_tx_bit == 4'd9) begin
          r_tx_bit <= '0;
          if (r_tx_byte == 2'd3) begin
            r_tx_active <= 1'b0;
            r_tx        <= 1'b1;
          end else begin
            r_tx_byte <= r_tx_byte + 1'b1;
            r_tx_sh   <= {8'h00, r_tx_sh[31:8]};
            r_tx      <= 1'b0;
          end
        end else begin
          r_tx_bit <= r_tx_bit + 1'b1;
          r_tx     <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_sh[r_tx_bit[2:0]];
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_instr_server.sv
// Bench for uart_instr_server: directed vector table, corner-case sequences
// and randomized requests checked against a behavioural RAM/address model.
module tb_uart_instr_server;
  localparam int unsigned CPB      = 8;
  localparam int unsigned AW       = 4;
  localparam int unsigned TMO_BITS = 20;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic          clk = 1'b0;
  logic          reset, rx, tx, prog_we, busy, resp_done, addr_err, frame_err;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data, last_pc;

  always #5 clk = ~clk;

  uart_instr_server #(
    .CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_BITS(TMO_BITS), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .busy(busy), .last_pc(last_pc), .resp_done(resp_done),
    .addr_err(addr_err), .frame_err(frame_err)
  );

  int total = 0, bad = 0;
  int n_done = 0, n_aerr = 0, n_ferr = 0, n_busy_bad = 0, n_stop_bad = 0, n_start_bad = 0;
  logic [7:0]  tx_q[$];
  logic [31:0] model_ram [16];

  typedef struct { logic [31:0] pc; logic [31:0] word; logic aerr; } vec_t;
  vec_t vecs[7];

  // Pulse counters
  always @(negedge clk) begin
    if (resp_done === 1'b1) begin
      n_done++;
      if (busy !== 1'b0) n_busy_bad++;
    end
    if (addr_err === 1'b1)  n_aerr++;
    if (frame_err === 1'b1) n_ferr++;
  end

  // UART decoder on tx
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        if (tx !== 1'b0) n_start_bad++;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        if (tx !== 1'b1) n_stop_bad++;
        tx_q.push_back(b);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic prog_write(input int a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
    model_ram[a] = d;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_pc(input logic [31:0] pc);
    for (int k = 0; k < 4; k++) send_byte(pc[8*k +: 8], 1'b1);
  endtask

  task automatic wait_done(input int d0);
    int cyc = 0;
    while (n_done == d0 && cyc < 80 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] q_word();
    if (tx_q.size() != 4) return 32'hxxxxxxxx;
    return {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
  endfunction

  // Reference: aligned PCs inside the 16-word RAM return the word, else NOP
  function automatic logic model_bad(input logic [31:0] pc);
    return (pc % 4 != 0) || (pc >= 32'd64);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] pc);
    if (model_bad(pc)) return NOP;
    return model_ram[int'(pc / 4)];
  endfunction

  task automatic do_request(input string tag, input logic [31:0] pc,
                            input logic [31:0] exp_w, input logic exp_ae);
    int d0 = n_done;
    int a0 = n_aerr;
    int cyc = 0;
    repeat (2 * CPB) @(negedge clk);
    tx_q.delete();
    send_pc(pc);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    while (tx !== 1'b0 && cyc < 4 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_start"}, 32'(cyc <= int'(CPB)), 32'd1);
    wait_done(d0);
    check({tag, "_done"}, 32'(n_done - d0), 32'd1);
    check({tag, "_word"}, q_word(), exp_w);
    check({tag, "_aerr"}, 32'(n_aerr - a0), 32'(exp_ae));
    check({tag, "_lastpc"}, last_pc, pc);
  endtask

  initial begin
    int d0, f0, a0, cyc, sel;
    logic [31:0] pc;

    reset = 1'b1; rx = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    vecs[0] = '{32'h0000000C, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{32'h00000006, NOP,          1'b1};
    vecs[2] = '{32'h00000040, NOP,          1'b1};
    vecs[3] = '{32'h00000000, 32'hCAFE0000, 1'b0};
    vecs[4] = '{32'h0000003C, 32'h0F0FA5A5, 1'b0};
    vecs[5] = '{32'h0000003F, NOP,          1'b1};
    vecs[6] = '{32'h80000000, NOP,          1'b1};

    // RAM is loaded while reset is held
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) prog_write(i, 32'h11110000 + 32'(i));
    prog_write(0, 32'hCAFE0000);
    prog_write(3, 32'hDEADBEEF);
    prog_write(15, 32'h0F0FA5A5);
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lastpc", last_pc, 32'd0);
    check("rst_pulses", 32'({resp_done, addr_err, frame_err}), 32'd0);
    reset = 1'b0;
    repeat (4 * CPB) @(negedge clk);

    for (int i = 0; i < 7; i++)
      do_request($sformatf("vec%0d", i), vecs[i].pc, vecs[i].word, vecs[i].aerr);

    // Partial request followed by a long idle gap
    repeat (2 * CPB) @(negedge clk);
    f0 = n_ferr; tx_q.delete();
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    check("tmo_busy_before", 32'(busy), 32'd1);
    repeat (21 * CPB) @(negedge clk);
    check("tmo_ferr", 32'(n_ferr - f0), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_no_tx", 32'(tx_q.size()), 32'd0);
    do_request("after_tmo", 32'h0, 32'hCAFE0000, 1'b0);

    // Bad stop bit on the second request byte restarts assembly
    repeat (2 * CPB) @(negedge clk);
    f0 = n_ferr;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check("stop_ferr", 32'(n_ferr - f0), 32'd1);
    check("stop_busy", 32'(busy), 32'd0);
    do_request("after_stop", 32'h0000000C, 32'hDEADBEEF, 1'b0);

    // Short low glitch in idle
    repeat (2 * CPB) @(negedge clk);
    d0 = n_done; a0 = n_aerr; f0 = n_ferr; tx_q.delete();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd0);
    check("glitch_pulses", 32'((n_done - d0) + (n_aerr - a0) + (n_ferr - f0)), 32'd0);
    check("glitch_tx", 32'(tx_q.size()), 32'd0);

    // Extra byte arriving while the response is being sent
    d0 = n_done; tx_q.delete();
    send_pc(32'h0000003C);
    repeat (CPB) @(negedge clk);
    send_byte(8'hA5, 1'b1);
    wait_done(d0);
    check("dup_word", q_word(), 32'h0F0FA5A5);
    repeat (60 * CPB) @(negedge clk);
    check("dup_done", 32'(n_done - d0), 32'd1);
    check("dup_txbytes", 32'(tx_q.size()), 32'd4);
    check("dup_busy", 32'(busy), 32'd0);

    // Reset during the second response byte
    repeat (2 * CPB) @(negedge clk);
    d0 = n_done; tx_q.delete(); cyc = 0;
    send_pc(32'h0000000C);
    while (tx_q.size() < 1 && cyc < 40 * CPB) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3 * CPB) @(negedge clk);
    check("rmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("rmid_tx", 32'(tx), 32'd1);
    check("rmid_busy", 32'(busy), 32'd0);
    repeat (12 * CPB) @(negedge clk);
    reset = 1'b0;
    check("rmid_no_done", 32'(n_done - d0), 32'd0);
    tx_q.delete();
    do_request("post_rst", 32'h0000000C, 32'hDEADBEEF, 1'b0);

    // Randomized writes and requests against the reference model
    for (int n = 0; n < 8; n++) begin
      prog_write(int'($urandom_range(0, 15)), $urandom);
      sel = int'($urandom_range(0, 2));
      case (sel)
        0:       pc = 32'($urandom_range(0, 15)) << 2;
        1:       pc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        default: pc = ($urandom & 32'hFFFFFFFC) | (32'h40 << $urandom_range(0, 25));
      endcase
      do_request($sformatf("rand%0d", n), pc, model_word(pc), model_bad(pc));
    end

    check("busy_at_done", 32'(n_busy_bad), 32'd0);
    check("tx_stop_bits", 32'(n_stop_bad), 32'd0);
    check("tx_start_bits", 32'(n_start_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
